// File: rtl/probe_trace_pkg.sv
// Shared encodings for the probe trace buffer: capture state, full-buffer mode,
// drop counter width and the channel index width helper.
package probe_trace_pkg;

    localparam int DROP_CNT_W = 16;

    typedef enum logic {
        ARMED  = 1'b0,
        FROZEN = 1'b1
    } trace_state_t;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_STOP = 1'b1
    } trace_mode_t;

    // A single channel still needs a one-bit index so read_chan never collapses to zero width.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/probe_trace_arbiter.sv
// Fixed-priority write-channel select: the lowest-index asserted strobe wins, and
// o_lost flags that at least one other asserted strobe lost this cycle.
module probe_trace_arbiter
    import probe_trace_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int CHANNELS = 2,
    parameter int IDX_W    = idx_width(CHANNELS)
) (
    input  logic [CHANNELS*DATA_W-1:0] i_write,
    input  logic [CHANNELS-1:0]        i_wen,
    output logic                       o_grant_valid,
    output logic [IDX_W-1:0]           o_grant_idx,
    output logic [DATA_W-1:0]          o_grant_data,
    output logic                       o_lost
);

    // Scanning from the top down lets the lowest asserted index overwrite last.
    always_comb begin
        o_grant_idx  = '0;
        o_grant_data = '0;
        for (int i = CHANNELS - 1; i >= 0; i--) begin
            if (i_wen[i]) begin
                o_grant_idx  = IDX_W'(i);
                o_grant_data = i_write[i*DATA_W +: DATA_W];
            end
        end
    end

    assign o_grant_valid = |i_wen;
    assign o_lost        = (i_wen & (i_wen - CHANNELS'(1))) != '0;

endmodule

// File: rtl/probe_trace_buffer.sv
// Multi-channel probe capture FIFO with wrap or stop-when-full behaviour, a
// freeze/clear capture FSM, sticky overflow and a saturating drop counter.
module probe_trace_buffer
    import probe_trace_pkg::*;
#(
    parameter int DATA_W   = 64,
    parameter int DEPTH    = 16,
    parameter int CHANNELS = 2
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [CHANNELS*DATA_W-1:0]     write,
    input  logic [CHANNELS-1:0]            wen,
    input  logic                           mode,
    input  logic                           freeze,
    input  logic                           clear,
    input  logic                           read_ready,
    output logic                           read_valid,
    output logic [DATA_W-1:0]              read_data,
    output logic [idx_width(CHANNELS)-1:0] read_chan,
    output logic [$clog2(DEPTH):0]         count,
    output logic                           overflow,
    output logic [DROP_CNT_W-1:0]          drop_count,
    output logic                           frozen
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int IDX_W = idx_width(CHANNELS);
    localparam int CNT_W = PTR_W + 1;

    trace_state_t          r_state;
    trace_state_t          w_nextState;
    logic [PTR_W-1:0]      r_rdPtr;
    logic [PTR_W-1:0]      r_wrPtr;
    logic [CNT_W-1:0]      r_count;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_dropCount;
    logic [DATA_W-1:0]     r_memData [DEPTH];
    logic [IDX_W-1:0]      r_memChan [DEPTH];

    logic              w_grantValid;
    logic [IDX_W-1:0]  w_grantIdx;
    logic [DATA_W-1:0] w_grantData;
    logic              w_lost;
    trace_mode_t       w_mode;
    logic              w_full;
    logic              w_pop;
    logic              w_capture;
    logic              w_write;
    logic              w_overwrite;
    logic              w_refuse;
    logic              w_drop;

    probe_trace_arbiter #(
        .DATA_W   (DATA_W),
        .CHANNELS (CHANNELS),
        .IDX_W    (IDX_W)
    ) u_arbiter (
        .i_write       (write),
        .i_wen         (wen),
        .o_grant_valid (w_grantValid),
        .o_grant_idx   (w_grantIdx),
        .o_grant_data  (w_grantData),
        .o_lost        (w_lost)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= ARMED;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        if (clear) begin
            w_nextState = ARMED;
        end else if (freeze) begin
            w_nextState = FROZEN;
        end
    end

    // Capture is suppressed already in the cycle freeze is first seen, not only once FROZEN.
    assign w_mode      = trace_mode_t'(mode);
    assign w_full      = (r_count == CNT_W'(DEPTH));
    assign w_pop       = read_valid && read_ready && !clear;
    assign w_capture   = (r_state == ARMED) && !freeze && !clear && w_grantValid;
    assign w_write     = w_capture && (!w_full || w_pop || (w_mode == MODE_WRAP));
    assign w_overwrite = w_capture && w_full && !w_pop && (w_mode == MODE_WRAP);
    assign w_refuse    = w_capture && w_full && !w_pop && (w_mode == MODE_STOP);
    assign w_drop      = w_grantValid && (w_lost || !w_write);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else if (clear) begin
            r_rdPtr     <= '0;
            r_wrPtr     <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_dropCount <= '0;
        end else begin
            if (w_write) begin
                r_wrPtr <= r_wrPtr + 1'b1;
            end
            if (w_pop || w_overwrite) begin
                r_rdPtr <= r_rdPtr + 1'b1;
            end
            if (w_write && !w_pop && !w_overwrite) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_write) begin
                r_count <= r_count - 1'b1;
            end
            if (w_overwrite || w_refuse) begin
                r_overflow <= 1'b1;
            end
            if (w_drop && (r_dropCount != '1)) begin
                r_dropCount <= r_dropCount + 1'b1;
            end
        end
    end

    // Storage is deliberately unreset; the pointers and count alone define what is valid.
    always_ff @(posedge clock) begin
        if (w_write) begin
            r_memData[r_wrPtr] <= w_grantData;
            r_memChan[r_wrPtr] <= w_grantIdx;
        end
    end

    assign read_valid = (r_count != '0);
    assign read_data  = r_memData[r_rdPtr];
    assign read_chan  = r_memChan[r_rdPtr];
    assign count      = r_count;
    assign overflow   = r_overflow;
    assign drop_count = r_dropCount;
    assign frozen     = (r_state == FROZEN);

endmodule

// File: doc/probe_trace_buffer.md
PROBE_TRACE_BUFFER -- requirements
Module: probe_trace_buffer

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of one probe sample.
REQ-002 SHALL have parameter DEPTH, default 16, entry count; power of two, >= 2.
REQ-003 SHALL have parameter CHANNELS, default 2, number of probe write channels; >= 1.
REQ-004 SHALL have port clock  input  1  sole clock, rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port write  input  CHANNELS*DATA_W  probe samples, channel i at bits [i*DATA_W +: DATA_W].
REQ-007 SHALL have port wen  input  CHANNELS  per-channel write strobe.
REQ-008 SHALL have port mode  input  1  0 = wrap (overwrite oldest), 1 = stop-when-full.
REQ-009 SHALL have port freeze  input  1  stop capture; level-sampled each cycle.
REQ-010 SHALL have port clear  input  1  flush buffer, counters and flags.
REQ-011 SHALL have port read_ready  input  1  consumer accepts head entry.
REQ-012 SHALL have port read_valid  output  1  head entry available.
REQ-013 SHALL have port read_data  output  DATA_W  head entry sample.
REQ-014 SHALL have port read_chan  output  max(1,clog2(CHANNELS))  channel index of head entry.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  entries held.
REQ-016 SHALL have port overflow  output  1  sticky: an entry was overwritten or refused.
REQ-017 SHALL have port drop_count  output  16  saturating count of cycles that lost a sample.
REQ-018 SHALL have port frozen  output  1  state == FROZEN.

Function
REQ-019 SHALL implement states ARMED and FROZEN; ARMED -> FROZEN when freeze=1; FROZEN -> ARMED only on clear=1.
REQ-020 SHALL, in ARMED, store at most one sample per cycle: lowest-index channel with wen set wins; entry records sample and channel index.
REQ-021 SHALL store no samples in FROZEN, nor in the cycle freeze is first sampled high.
REQ-022 SHALL make a stored entry visible on read_valid/count the cycle after the write edge (latency 1).
REQ-023 SHALL drive read_valid = (count != 0); read_data/read_chan = head entry, combinationally from storage; undefined-but-stable when empty.
REQ-024 SHALL pop the head on read_valid && read_ready, in either state.
REQ-025 SHALL keep count unchanged on simultaneous push and pop, including at full; overflow not set in that case.
REQ-026 SHALL, when full with push and no pop, in mode 0 overwrite oldest (head advances, count stays DEPTH), in mode 1 drop the sample; both set overflow.
REQ-027 SHALL increment drop_count by 1 per cycle in which >=1 asserted wen bit was not stored (arbitration loss, mode-1 full, FROZEN); saturate at 16'hFFFF.
REQ-028 SHALL wrap read/write pointers modulo DEPTH with no gap or duplicate entry.
REQ-029 SHALL, on clear, in the next cycle show count 0, read_valid 0, overflow 0, drop_count 0, state ARMED; clear has priority over push, pop and freeze in that cycle.
REQ-030 SHALL treat mode changes as effective on the next push decision; stored contents unaffected.

Reset
REQ-031 SHALL on reset assertion immediately force: state ARMED, pointers 0, count 0, read_valid 0, overflow 0, drop_count 0, frozen 0.
REQ-032 SHALL not require storage contents to be reset; read_data/read_chan unspecified while empty.
REQ-033 SHALL abandon any in-flight push/pop when reset asserts mid-operation; first push is accepted on the first rising edge after deassertion.

Structure
REQ-034 SHALL place state encoding (ARMED/FROZEN), mode encoding and DROP_CNT_W=16 in shared package probe_trace_pkg.
REQ-035 SHALL split off one sub-module probe_trace_arbiter: fixed-priority CHANNELS-way select producing grant valid, index, sample and lost flag.
REQ-036 SHALL keep storage as a flop array, no SRAM macro, synthesizable without blackbox attributes.

Verification (DEPTH=4, CHANNELS=2, DATA_W=64)
REQ-037 SHALL cover: wen=2'b01 write=0xA on one cycle, read_ready=0 -> next cycle count=1, read_valid=1, read_data=0xA, read_chan=0.
REQ-038 SHALL cover: wen=2'b11 ch0=0x1 ch1=0x2 -> one entry 0x1 chan 0, drop_count=1.
REQ-039 SHALL cover: mode 0, push 0x1..0x5, no reads -> count=4, head 0x2, overflow=1; drained order 0x2,0x3,0x4,0x5.
REQ-040 SHALL cover: mode 1, push 0x1..0x5 -> head 0x1, count=4, overflow=1, drop_count=1; at full push+pop same cycle -> count=4, no new drop.
REQ-041 SHALL cover: freeze=1 then wen=2'b01 for 3 cycles -> count unchanged, frozen=1, drop_count+3; reads still drain; clear -> all zero, ARMED.
REQ-042 SHALL cover: reset asserted mid-push with count=3 -> outputs zero asynchronously before next edge; after release push 0x7 -> count=1, head 0x7.
